// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: launch FSM encoding and
// the default serializer bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    // 100 MHz clock / 115200 baud
    localparam int CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and serializer-handshake signals of uart_tx_fifo.
// slave is the FIFO side, master is the producer/serializer side.
interface uart_tx_fifo_if #(
    parameter int CNT_W = 5
);
    logic             i_Wr_DV;
    logic [7:0]       i_Wr_Byte;
    logic             o_Full;
    logic             o_Empty;
    logic [CNT_W-1:0] o_Count;
    logic             o_Overflow;
    logic             o_TX_DV;
    logic [7:0]       o_TX_Byte;
    logic             i_TX_Active;
    logic             i_TX_Done;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_TX_Active, i_TX_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_DV, o_TX_Byte
    );
endinterface

// File: rtl/uart_byte_fifo.sv
// DEPTH x 8 circular byte buffer with registered count/flags and a
// one-cycle overflow pulse for dropped writes.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             iclk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_DV,
    input  logic [7:0]       i_Wr_Byte,
    input  logic             i_Pop,
    output logic [7:0]       o_Rd_Byte,
    output logic             o_Full,
    output logic             o_Empty,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_Mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_Wr_Ptr, r_Rd_Ptr;
    logic [CNT_W-1:0] r_Count, w_Count_Nxt;
    logic             r_Full, r_Empty, r_Overflow;
    logic             w_Pop, w_Wr_Acc;

    assign w_Pop    = i_Pop && !r_Empty;
    // A full FIFO still takes a write when the head leaves on the same edge
    assign w_Wr_Acc = i_Wr_DV && (!r_Full || w_Pop);

    always_comb begin
        w_Count_Nxt = r_Count;
        if (w_Wr_Acc && !w_Pop)
            w_Count_Nxt = r_Count + CNT_W'(1);
        else if (!w_Wr_Acc && w_Pop)
            w_Count_Nxt = r_Count - CNT_W'(1);
    end

    always_ff @(posedge iclk) begin
        if (w_Wr_Acc)
            r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge iclk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr   <= '0;
            r_Rd_Ptr   <= '0;
            r_Count    <= '0;
            r_Full     <= 1'b0;
            r_Empty    <= 1'b1;
            r_Overflow <= 1'b0;
        end else begin
            if (w_Wr_Acc)
                r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
            if (w_Pop)
                r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
            r_Count    <= w_Count_Nxt;
            r_Full     <= (w_Count_Nxt == CNT_W'(DEPTH));
            r_Empty    <= (w_Count_Nxt == '0);
            r_Overflow <= i_Wr_DV && !w_Wr_Acc;
        end
    end

    assign o_Rd_Byte  = r_Mem[r_Rd_Ptr];
    assign o_Full     = r_Full;
    assign o_Empty    = r_Empty;
    assign o_Count    = r_Count;
    assign o_Overflow = r_Overflow;
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART serializer: buffers bytes and launches
// one at a time, waiting for the serializer's done pulse between launches.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic          iclk,
    input  logic          i_Rst_L,
    uart_tx_fifo_if.slave bus
);
    tx_state_e        r_State;
    logic             r_TX_DV;
    logic [7:0]       r_TX_Byte;
    logic             w_Pop;
    logic [7:0]       w_Rd_Byte;
    logic             w_Full, w_Empty, w_Overflow;
    logic [CNT_W-1:0] w_Count;

    // The pop happens on the IDLE->LAUNCH edge, when the head is latched
    assign w_Pop = (r_State == ST_IDLE) && !w_Empty;

    uart_byte_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .iclk       (iclk),
        .i_Rst_L    (i_Rst_L),
        .i_Wr_DV    (bus.i_Wr_DV),
        .i_Wr_Byte  (bus.i_Wr_Byte),
        .i_Pop      (w_Pop),
        .o_Rd_Byte  (w_Rd_Byte),
        .o_Full     (w_Full),
        .o_Empty    (w_Empty),
        .o_Count    (w_Count),
        .o_Overflow (w_Overflow)
    );

    always_ff @(posedge iclk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State   <= ST_IDLE;
            r_TX_DV   <= 1'b0;
            r_TX_Byte <= 8'h00;
        end else begin
            r_TX_DV <= 1'b0;
            case (r_State)
                ST_IDLE: if (!w_Empty) begin
                    r_TX_Byte <= w_Rd_Byte;
                    r_TX_DV   <= 1'b1;
                    r_State   <= ST_LAUNCH;
                end
                ST_LAUNCH: r_State <= ST_WAIT_BUSY;
                // A serializer that finishes before showing busy still ends the wait
                ST_WAIT_BUSY: begin
                    if (bus.i_TX_Done)
                        r_State <= ST_IDLE;
                    else if (bus.i_TX_Active)
                        r_State <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: if (bus.i_TX_Done) r_State <= ST_IDLE;
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_Full     = w_Full;
    assign bus.o_Empty    = w_Empty;
    assign bus.o_Count    = w_Count;
    assign bus.o_Overflow = w_Overflow;
    assign bus.o_TX_DV    = r_TX_DV;
    assign bus.o_TX_Byte  = r_TX_Byte;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4): latency, burst spacing,
// overflow, full+pop, pointer wrap and mid-operation reset.
module tb_uart_tx_fifo;
    logic iclk;
    logic i_Rst_L;
    int   n_vec = 0;
    int   n_err = 0;

    uart_tx_fifo_if #(.CNT_W(3)) bus ();

    uart_tx_fifo #(.DEPTH(4), .CNT_W(3)) dut (
        .iclk    (iclk),
        .i_Rst_L (i_Rst_L),
        .bus     (bus)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_count"}, 32'(bus.o_Count), 0);
        chk({pfx, "_empty"}, 32'(bus.o_Empty), 1);
        chk({pfx, "_full"},  32'(bus.o_Full), 0);
        chk({pfx, "_ovf"},   32'(bus.o_Overflow), 0);
        chk({pfx, "_dv"},    32'(bus.o_TX_DV), 0);
        chk({pfx, "_byte"},  32'(bus.o_TX_Byte), 0);
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int n, dv_cyc, done_cyc;
    logic busy;

    initial begin
        i_Rst_L = 1'b0;
        bus.i_Wr_DV = 0; bus.i_Wr_Byte = 0; bus.i_TX_Active = 0; bus.i_TX_Done = 0;
        repeat (2) @(negedge iclk);
        chk_reset("rst");
        i_Rst_L = 1'b1;

        // single byte: launch two cycles after the write
        @(negedge iclk); bus.i_Wr_DV = 1; bus.i_Wr_Byte = 8'hA5;
        @(negedge iclk); bus.i_Wr_DV = 0;
        chk("single_dv_early", 32'(bus.o_TX_DV), 0);
        @(negedge iclk);
        chk("single_dv", 32'(bus.o_TX_DV), 1);
        chk("single_byte", 32'(bus.o_TX_Byte), 32'hA5);
        chk("single_empty", 32'(bus.o_Empty), 1);
        chk("single_count", 32'(bus.o_Count), 0);
        @(negedge iclk);
        chk("single_dv_pulse", 32'(bus.o_TX_DV), 0);
        bus.i_TX_Done = 1;
        @(negedge iclk); bus.i_TX_Done = 0;

        // burst 01..04 with serializer: Active from DV+1, Done at DV+20
        n = 0; busy = 0; dv_cyc = 0; done_cyc = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            @(negedge iclk);
            if (bus.o_TX_DV) begin
                chk("burst_byte", 32'(bus.o_TX_Byte), 32'(n + 1));
                chk("burst_gap", 32'(cyc), (n == 0) ? 32'd2 : 32'(done_cyc + 2));
                n++; dv_cyc = cyc; busy = 1;
            end
            bus.i_Wr_DV   = (cyc < 4);
            bus.i_Wr_Byte = 8'(cyc + 1);
            bus.i_TX_Active = busy && (cyc >= dv_cyc + 1) && (cyc < dv_cyc + 20);
            bus.i_TX_Done   = busy && (cyc == dv_cyc + 20);
            if (bus.i_TX_Done) begin busy = 0; done_cyc = cyc; end
        end
        bus.i_Wr_DV = 0; bus.i_TX_Active = 0; bus.i_TX_Done = 0;
        chk("burst_launches", 32'(n), 4);
        chk("burst_empty", 32'(bus.o_Empty), 1);

        // overflow: park serializer busy on a primer byte, then write 6
        @(negedge iclk); bus.i_Wr_DV = 1; bus.i_Wr_Byte = 8'h10;
        @(negedge iclk); bus.i_Wr_DV = 0;
        @(negedge iclk);
        chk("ovf_primer_dv", 32'(bus.o_TX_DV), 1);
        chk("ovf_primer_byte", 32'(bus.o_TX_Byte), 32'h10);
        bus.i_TX_Active = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge iclk);
            if (k > 0) begin
                chk("ovf_pulse", 32'(bus.o_Overflow), (k - 1 >= 4) ? 32'd1 : 32'd0);
                chk("ovf_count", 32'(bus.o_Count), (k > 4) ? 32'd4 : 32'(k));
            end
            bus.i_Wr_DV   = (k < 6);
            bus.i_Wr_Byte = 8'hB0 + 8'(k);
        end
        @(negedge iclk);
        chk("ovf_pulse_end", 32'(bus.o_Overflow), 0);
        chk("ovf_full", 32'(bus.o_Full), 1);
        chk("ovf_count_end", 32'(bus.o_Count), 4);
        chk("ovf_no_dv", 32'(bus.o_TX_DV), 0);

        // full FIFO, write lands on the pop edge
        bus.i_TX_Active = 0; bus.i_TX_Done = 1;
        @(negedge iclk); bus.i_TX_Done = 0; bus.i_Wr_DV = 1; bus.i_Wr_Byte = 8'hC0;
        @(negedge iclk); bus.i_Wr_DV = 0;
        chk("fullpop_dv", 32'(bus.o_TX_DV), 1);
        chk("fullpop_byte", 32'(bus.o_TX_Byte), 32'hB0);
        chk("fullpop_ovf", 32'(bus.o_Overflow), 0);
        chk("fullpop_count", 32'(bus.o_Count), 4);
        chk("fullpop_full", 32'(bus.o_Full), 1);

        // wrap: drain B1..B3,C0 while feeding D0..D9; Done straight from WAIT_BUSY
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        n = 0; dv_cyc = -1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge iclk);
            if (bus.o_TX_DV) begin
                if (exp_q.size() == 0) begin
                    chk("wrap_extra_dv", 32'(bus.o_TX_DV), 0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("wrap_order", 32'(bus.o_TX_Byte), 32'(exp_b));
                end
                n++; dv_cyc = cyc;
            end
            chk("wrap_ovf", 32'(bus.o_Overflow), 0);
            bus.i_TX_Done = (cyc == dv_cyc + 1);
            bus.i_Wr_DV   = (cyc % 4 == 0) && (cyc >= 4) && (cyc < 44);
            bus.i_Wr_Byte = 8'hD0 + 8'((cyc - 4) / 4);
            if (bus.i_Wr_DV) exp_q.push_back(bus.i_Wr_Byte);
        end
        bus.i_Wr_DV = 0; bus.i_TX_Done = 0;
        chk("wrap_launches", 32'(n), 14);
        chk("wrap_left", 32'(exp_q.size()), 0);
        chk("wrap_empty", 32'(bus.o_Empty), 1);

        // reset in WAIT_DONE with three bytes queued
        for (int k = 0; k < 5; k++) begin
            @(negedge iclk);
            if (k == 2) begin
                chk("rstmid_dv", 32'(bus.o_TX_DV), 1);
                chk("rstmid_byte", 32'(bus.o_TX_Byte), 32'hE0);
            end
            if (k == 4) chk("rstmid_count", 32'(bus.o_Count), 3);
            bus.i_Wr_DV   = (k < 4);
            bus.i_Wr_Byte = 8'hE0 + 8'(k);
            if (k >= 2) bus.i_TX_Active = 1;
        end
        bus.i_Wr_DV = 0;
        i_Rst_L = 0;
        #1;
        chk_reset("rstmid");
        bus.i_TX_Active = 0;
        @(negedge iclk); i_Rst_L = 1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge iclk);
            if (bus.o_TX_DV) n++;
        end
        chk("rstmid_no_dv", 32'(n), 0);
        bus.i_Wr_DV = 1; bus.i_Wr_Byte = 8'hF1;
        @(negedge iclk); bus.i_Wr_DV = 0;
        @(negedge iclk);
        chk("rstmid_new_dv", 32'(bus.o_TX_DV), 1);
        chk("rstmid_new_byte", 32'(bus.o_TX_Byte), 32'hF1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
